// File: rtl/svga_pkg.sv
// rtl/svga_pkg.sv - shared state encoding and slot constants for the SVGA VRAM arbiter
package svga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VADDR,
    ST_VREAD,
    ST_CADDR,
    ST_CREAD
  } arb_state_t;

  localparam logic [3:0] VID_SLOT_DEF = 4'd1;
  localparam int         ACCESS_EDGES = 3;

  // Pixels remaining, mod 16, from a phase forward to the given slot.
  function automatic logic [3:0] slot_dist(input logic [3:0] phase, input logic [3:0] slot);
    return slot - phase;
  endfunction

endpackage

// File: rtl/svga_slot_window.sv
// rtl/svga_slot_window.sv - mod-16 decode of the video slot and the CPU keep-out window before it
module svga_slot_window
  import svga_pkg::*;
#(
  parameter logic [3:0] VID_SLOT = VID_SLOT_DEF
)(
  input  logic [3:0] i_slot_phase,
  input  logic       i_video_active,
  output logic       o_blocked,
  output logic       o_vid_slot
);

  logic [3:0] w_dist;

  assign w_dist = slot_dist(i_slot_phase, VID_SLOT);

  // A grant fewer than ACCESS_EDGES pixels before the slot would still be in flight when it arrives.
  assign o_blocked  = i_video_active & (int'(w_dist) < ACCESS_EDGES);
  assign o_vid_slot = i_video_active & (w_dist == 4'd0);

endmodule

// File: rtl/svga_vram_arbiter.sv
// rtl/svga_vram_arbiter.sv - time-slot VRAM arbiter: fixed video fetch slot per cell, CPU gets the rest
module svga_vram_arbiter
  import svga_pkg::*;
#(
  parameter int         ADDR_W   = 13,
  parameter logic [3:0] VID_SLOT = VID_SLOT_DEF
)(
  input  logic              i_pixel_clock,
  input  logic              i_reset_n,
  input  logic [3:0]        i_slot_phase,
  input  logic              i_video_active,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic [7:0]        o_vid_data,
  output logic              o_vid_valid,
  output logic              o_vid_miss,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_wdata,
  output logic [7:0]        o_cpu_rdata,
  output logic              o_cpu_ack,
  output logic              o_cpu_wait,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [7:0]        o_ram_wdata,
  input  logic [7:0]        i_ram_rdata
);

  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [7:0]        r_ram_wdata;
  logic [7:0]        r_vid_data;
  logic              r_vid_valid;
  logic              r_vid_miss;
  logic [7:0]        r_cpu_rdata;
  logic              r_cpu_ack;
  logic              r_cpu_we;
  logic              r_armed;
  logic              r_done;

  logic w_blocked;
  logic w_vid_slot;
  logic w_cpu_go;

  svga_slot_window #(.VID_SLOT(VID_SLOT)) u_slot_window (
    .i_slot_phase   (i_slot_phase),
    .i_video_active (i_video_active),
    .o_blocked      (w_blocked),
    .o_vid_slot     (w_vid_slot)
  );

  assign w_cpu_go = i_cpu_req & r_armed & ~w_blocked;

  always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= 8'd0;
      r_vid_data  <= 8'd0;
      r_vid_valid <= 1'b0;
      r_vid_miss  <= 1'b0;
      r_cpu_rdata <= 8'd0;
      r_cpu_ack   <= 1'b0;
      r_cpu_we    <= 1'b0;
      r_armed     <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_vid_valid <= 1'b0;
      r_vid_miss  <= 1'b0;
      r_cpu_ack   <= 1'b0;
      if (!i_cpu_req) begin
        r_armed <= 1'b1;
        r_done  <= 1'b0;
      end
      // Only reachable if video_active rose while a CPU access was already running.
      if (w_vid_slot && (r_state != ST_IDLE)) begin
        r_vid_miss <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_vid_slot) begin
            r_ram_addr <= i_vid_addr;
            r_ram_we   <= 1'b0;
            r_state    <= ST_VADDR;
          end else if (w_cpu_go) begin
            r_ram_addr  <= i_cpu_addr;
            r_ram_we    <= i_cpu_we;
            r_ram_wdata <= i_cpu_wdata;
            r_cpu_we    <= i_cpu_we;
            r_state     <= ST_CADDR;
          end
        end
        ST_VADDR: begin
          r_ram_we <= 1'b0;
          r_state  <= ST_VREAD;
        end
        ST_VREAD: begin
          r_vid_data  <= i_ram_rdata;
          r_vid_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        ST_CADDR: begin
          r_ram_we <= 1'b0;
          r_state  <= ST_CREAD;
        end
        ST_CREAD: begin
          if (!r_cpu_we) begin
            r_cpu_rdata <= i_ram_rdata;
          end
          r_cpu_ack <= 1'b1;
          r_armed   <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ram_addr  = r_ram_addr;
  assign o_ram_we    = r_ram_we;
  assign o_ram_wdata = r_ram_wdata;
  assign o_vid_data  = r_vid_data;
  assign o_vid_valid = r_vid_valid;
  assign o_vid_miss  = r_vid_miss;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_cpu_wait  = i_cpu_req & ~r_cpu_ack & ~r_done;

endmodule

// File: tb/tb_svga_vram_arbiter.sv
// tb/tb_svga_vram_arbiter.sv - self-checking bench for svga_vram_arbiter
module tb_svga_vram_arbiter;

  localparam int AW   = 13;
  localparam int SLOT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    slot_phase;
  logic          video_active;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_data;
  logic          vid_valid;
  logic          vid_miss;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  svga_vram_arbiter dut (
    .i_pixel_clock  (clk),
    .i_reset_n      (rst_n),
    .i_slot_phase   (slot_phase),
    .i_video_active (video_active),
    .i_vid_addr     (vid_addr),
    .o_vid_data     (vid_data),
    .o_vid_valid    (vid_valid),
    .o_vid_miss     (vid_miss),
    .i_cpu_req      (cpu_req),
    .i_cpu_we       (cpu_we),
    .i_cpu_addr     (cpu_addr),
    .i_cpu_wdata    (cpu_wdata),
    .o_cpu_rdata    (cpu_rdata),
    .o_cpu_ack      (cpu_ack),
    .o_cpu_wait     (cpu_wait),
    .o_ram_addr     (ram_addr),
    .o_ram_we       (ram_we),
    .o_ram_wdata    (ram_wdata),
    .i_ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int a);
    if (a == 'h123) return 8'hA5;
    if (a == 'h200) return 8'h5A;
    return 8'(a * 7 + 3);
  endfunction

  // Synchronous single-port VRAM, one-clock read latency
  logic [7:0] mem [0:8191];
  bit         mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 8192; i++) mem[i] <= init_byte(i);
      mem_init_done <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each access is an interval [grant, grant+3) with its result due at grant+2
  logic [7:0]    ref_mem [0:8191];
  int unsigned   m_n, m_free_at, m_done_at;
  int            m_kind;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;
  logic [7:0]    ref_vdata, ref_rdata;
  bit            ref_armed, ref_done;
  bit            e_valid, e_miss, e_ack, e_we, e_grant;
  logic [AW-1:0] e_addr;

  task automatic model_reset();
    m_n = 0; m_free_at = 0; m_done_at = 0; m_kind = 0;
    ref_vdata = 8'd0; ref_rdata = 8'd0; ref_armed = 1'b1; ref_done = 1'b0;
    e_valid = 0; e_miss = 0; e_ack = 0; e_we = 0; e_grant = 0;
  endtask

  task automatic model_edge();
    bit vslot, blk, busy;
    vslot = video_active && (int'(slot_phase) == SLOT);
    blk = 1'b0;
    for (int k = 0; k < 3; k++)
      if (video_active && int'(slot_phase) == (SLOT + 16 - k) % 16) blk = 1'b1;
    busy = (m_n < m_free_at);
    e_valid = 0; e_miss = 0; e_ack = 0; e_we = 0; e_grant = 0;
    if (m_kind != 0 && m_n == m_done_at) begin
      if (m_kind == 1) begin
        ref_vdata = m_data; e_valid = 1;
      end else begin
        if (m_we) ref_mem[m_addr] = m_data;
        else ref_rdata = m_data;
        e_ack = 1;
      end
      m_kind = 0;
    end
    if (busy) begin
      e_miss = vslot;
    end else if (vslot) begin
      m_kind = 1; m_data = ref_mem[vid_addr]; e_addr = vid_addr; e_grant = 1;
    end else if (cpu_req && ref_armed && !blk) begin
      m_kind = 2; m_we = cpu_we; m_addr = cpu_addr;
      m_data = cpu_we ? cpu_wdata : ref_mem[cpu_addr];
      e_we = cpu_we; e_addr = cpu_addr; e_grant = 1;
    end
    if (e_grant) begin
      m_done_at = m_n + 2; m_free_at = m_n + 3;
    end
    if (!cpu_req) begin ref_armed = 1'b1; ref_done = 1'b0; end
    if (e_ack) begin ref_armed = 1'b0; ref_done = 1'b1; end
    m_n++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    chk("vid_valid", 32'(vid_valid), 32'(e_valid));
    chk("vid_miss",  32'(vid_miss),  32'(e_miss));
    chk("cpu_ack",   32'(cpu_ack),   32'(e_ack));
    chk("ram_we",    32'(ram_we),    32'(e_we));
    chk("vid_data",  32'(vid_data),  32'(ref_vdata));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(ref_rdata));
    chk("cpu_wait",  32'(cpu_wait),  32'(cpu_req & ~e_ack & ~ref_done));
    if (e_grant) chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    if (e_grant && e_we) chk("ram_wdata", 32'(ram_wdata), 32'(m_data));
  endtask

  task automatic cpu_xfer(input logic we, input logic [AW-1:0] addr, input logic [7:0] wd,
                          output int ack_at, output int we_cyc);
    cpu_req = 1'b0;
    step();
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    ack_at = -1; we_cyc = 0;
    for (int i = 0; i < 40 && ack_at < 0; i++) begin
      step();
      if (ram_we) we_cyc++;
      if (cpu_ack) ack_at = i;
    end
    cpu_req = 1'b0;
  endtask

  typedef struct {
    logic [3:0] ph;
    logic       va;
    logic       req;
    logic       ev;
    logic       ea;
    logic       ew;
    logic       em;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  initial begin
    int ack_at, we_cyc, hold;
    bit acked;

    // Video fetch at phase 1 with a CPU read raised at phase 15 of the same cell
    tbl[0]  = '{4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{4'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{4'd4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{4'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{4'd6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{4'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 8192; i++) ref_mem[i] = init_byte(i);
    rst_n = 1'b0; slot_phase = 4'd0; video_active = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ram_we",    32'(ram_we),    32'd0);
    chk("reset ram_addr",  32'(ram_addr),  32'd0);
    chk("reset vid_data",  32'(vid_data),  32'd0);
    chk("reset cpu_ack",   32'(cpu_ack),   32'd0);
    chk("reset cpu_wait",  32'(cpu_wait),  32'd0);
    rst_n = 1'b1;
    model_reset();

    vid_addr = 13'h0123; cpu_addr = 13'h0200; cpu_we = 1'b0;
    for (int i = 0; i < NV; i++) begin
      slot_phase = tbl[i].ph; video_active = tbl[i].va; cpu_req = tbl[i].req;
      step();
      chk($sformatf("tbl[%0d] vid_valid", i), 32'(vid_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl[%0d] cpu_ack", i),   32'(cpu_ack),   32'(tbl[i].ea));
      chk($sformatf("tbl[%0d] cpu_wait", i),  32'(cpu_wait),  32'(tbl[i].ew));
      chk($sformatf("tbl[%0d] vid_miss", i),  32'(vid_miss),  32'(tbl[i].em));
      chk($sformatf("tbl[%0d] ram_we", i),    32'(ram_we),    32'd0);
      if (i == 6) chk("tbl vid_data", 32'(vid_data), 32'h0A5);
      if (i == 7) chk("tbl cpu grant addr", 32'(ram_addr), 32'h0200);
      if (i == 9) chk("tbl cpu_rdata", 32'(cpu_rdata), 32'h05A);
    end

    // Write then read back with video idle
    video_active = 1'b0; slot_phase = 4'd0;
    cpu_xfer(1'b1, 13'h0800, 8'h3C, ack_at, we_cyc);
    chk("wr ack latency", 32'(ack_at), 32'd2);
    chk("wr ram_we cycles", 32'(we_cyc), 32'd1);
    cpu_xfer(1'b0, 13'h0800, 8'h00, ack_at, we_cyc);
    chk("rd ack latency", 32'(ack_at), 32'd2);
    chk("rd ram_we cycles", 32'(we_cyc), 32'd0);
    chk("rd readback", 32'(cpu_rdata), 32'h03C);

    // video_active rises while a CPU write granted at phase 15 is in flight
    cpu_req = 1'b0; slot_phase = 4'd14; step();
    slot_phase = 4'd15; cpu_we = 1'b1; cpu_addr = 13'h0801; cpu_wdata = 8'h77; cpu_req = 1'b1;
    step();
    chk("miss grant ram_we", 32'(ram_we), 32'd1);
    slot_phase = 4'd0; video_active = 1'b1; step();
    slot_phase = 4'd1; step();
    chk("miss vid_miss", 32'(vid_miss), 32'd1);
    chk("miss cpu_ack", 32'(cpu_ack), 32'd1);
    chk("miss vid_valid", 32'(vid_valid), 32'd0);
    chk("miss vid_data held", 32'(vid_data), 32'h0A5);
    cpu_req = 1'b0; slot_phase = 4'd2; step();
    chk("miss one-cycle", 32'(vid_miss), 32'd0);
    video_active = 1'b0; slot_phase = 4'd5; step();

    // Reset asserted mid write
    cpu_we = 1'b1; cpu_addr = 13'h0802; cpu_wdata = 8'h99; cpu_req = 1'b1;
    step();
    chk("rst grant ram_we", 32'(ram_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async ram_we",  32'(ram_we),    32'd0);
    chk("rst ram_addr",      32'(ram_addr),  32'd0);
    chk("rst ram_wdata",     32'(ram_wdata), 32'd0);
    chk("rst vid_data",      32'(vid_data),  32'd0);
    chk("rst vid_valid",     32'(vid_valid), 32'd0);
    chk("rst vid_miss",      32'(vid_miss),  32'd0);
    chk("rst cpu_rdata",     32'(cpu_rdata), 32'd0);
    chk("rst cpu_ack",       32'(cpu_ack),   32'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    cpu_xfer(1'b0, 13'h0802, 8'h00, ack_at, we_cyc);
    chk("rst idle ack latency", 32'(ack_at), 32'd2);
    chk("rst aborted write", 32'(cpu_rdata), 32'(init_byte('h802)));

    // Randomized traffic against the reference model
    video_active = 1'b0; cpu_req = 1'b0; hold = 0; acked = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      slot_phase = 4'(c % 16);
      if ((c % 16) == 0 && $urandom_range(0, 2) == 0) video_active = ~video_active;
      else if ($urandom_range(0, 99) == 0) video_active = ~video_active;
      vid_addr = 13'($urandom_range(0, 63));
      step();
      if (cpu_req) begin
        if (cpu_ack) begin
          acked = 1'b1;
          hold = int'($urandom_range(0, 2));
        end
        if (acked) begin
          if (hold == 0) begin
            cpu_req = 1'b0; acked = 1'b0;
          end else begin
            hold--;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 13'($urandom_range(0, 63));
        cpu_wdata = 8'($urandom);
        cpu_req = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
